// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: latches cabin/hall calls, picks the next target floor and hands it to the motion FSM.
// Optional per-button debounce is enabled by defining CALL_DEBOUNCE_EN.
module elevator_call_scheduler #(
  parameter int N_FLOORS        = 3,
  parameter int FLOOR_W         = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N_FLOORS-1:0] call_i,
  input  logic [N_FLOORS-1:0] call_e,
  input  logic [N_FLOORS-1:0] at_floor,
  input  logic                cmd_ready,
  input  logic                served,
  output logic                cmd_valid,
  output logic [FLOOR_W-1:0]  cmd_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                dir_up,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  state_t               state_q;
  logic                 cmd_valid_q;
  logic [FLOOR_W-1:0]   cmd_floor_q;
  logic                 dir_up_q;
  logic                 busy_q;
  logic [N_FLOORS-1:0]  pending_q, pending_d;

  logic [N_FLOORS-1:0]  btn;
  logic [N_FLOORS-1:0]  press;
  logic [N_FLOORS-1:0]  clear_mask;

  assign btn = call_i | call_e;

`ifdef CALL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] deb_cnt_q [N_FLOORS];

  // Counter saturates at DEBOUNCE_CYCLES so a held button yields exactly one press pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int n = 0; n < N_FLOORS; n++) deb_cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < N_FLOORS; n++) begin
        if (!btn[n])
          deb_cnt_q[n] <= '0;
        else if (deb_cnt_q[n] != CNT_W'(DEBOUNCE_CYCLES))
          deb_cnt_q[n] <= deb_cnt_q[n] + 1'b1;
      end
    end
  end

  always_comb begin
    press = '0;
    for (int n = 0; n < N_FLOORS; n++)
      press[n] = btn[n] && (deb_cnt_q[n] == CNT_W'(DEBOUNCE_CYCLES - 1));
  end
`else
  assign press = btn;
`endif

  // Sensor decode: only a one-hot code names a valid current floor.
  logic               floor_valid;
  logic [FLOOR_W-1:0] cur_floor;

  assign floor_valid = (at_floor != '0) && ((at_floor & (at_floor - 1'b1)) == '0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_floor = '0;
    for (int i = 0; i < N_FLOORS; i++)
      if (at_floor[i]) cur_floor = FLOOR_W'(i);
  end

  logic               here_hit;
  logic               found_above, found_below;
  logic [FLOOR_W-1:0] above_floor, below_floor;
  logic [FLOOR_W-1:0] tgt_floor;
  logic               tgt_dir_up;

  assign here_hit = |(pending_q & at_floor);

  always_comb begin
    found_above = 1'b0;
    above_floor = '0;
    found_below = 1'b0;
    below_floor = '0;
    // Downward scan leaves the nearest call above; upward scan leaves the nearest below.
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (FLOOR_W'(i) > cur_floor)) begin
        found_above = 1'b1;
        above_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending_q[i] && (FLOOR_W'(i) < cur_floor)) begin
        found_below = 1'b1;
        below_floor = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    tgt_floor  = cur_floor;
    tgt_dir_up = dir_up_q;
    if (here_hit) begin
      tgt_floor  = cur_floor;
      tgt_dir_up = dir_up_q;
    end else if (dir_up_q && found_above) begin
      tgt_floor  = above_floor;
    end else if (!dir_up_q && found_below) begin
      tgt_floor  = below_floor;
    end else if (dir_up_q) begin
      tgt_floor  = below_floor;
      tgt_dir_up = 1'b0;
    end else begin
      tgt_floor  = above_floor;
      tgt_dir_up = 1'b1;
    end
  end

  // Clear of the served floor masks any same-cycle press of that floor.
  always_comb begin
    clear_mask = '0;
    if ((state_q == S_BUSY) && served)
      for (int i = 0; i < N_FLOORS; i++)
        clear_mask[i] = (cmd_floor_q == FLOOR_W'(i));
    pending_d = (pending_q | press) & ~clear_mask;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_floor_q <= '0;
      dir_up_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: begin
          if ((pending_q != '0) && floor_valid) begin
            cmd_floor_q <= tgt_floor;
            dir_up_q    <= tgt_dir_up;
            cmd_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (served) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          cmd_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_floor = cmd_floor_q;
  assign pending   = pending_q;
  assign dir_up    = dir_up_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Table-driven bench for elevator_call_scheduler: directed vectors with hand-computed expectations.
// Debounce rows are used instead of the default table when CALL_DEBOUNCE_EN is defined.
module tb_elevator_call_scheduler;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] call_i, call_e, at_floor;
  logic       cmd_ready, served;
  logic       cmd_valid, dir_up, busy;
  logic [1:0] cmd_floor;
  logic [2:0] pending;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  elevator_call_scheduler #(.N_FLOORS(3), .FLOOR_W(2), .DEBOUNCE_CYCLES(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .call_i    (call_i),
    .call_e    (call_e),
    .at_floor  (at_floor),
    .cmd_ready (cmd_ready),
    .served    (served),
    .cmd_valid (cmd_valid),
    .cmd_floor (cmd_floor),
    .pending   (pending),
    .dir_up    (dir_up),
    .busy      (busy)
  );

  typedef struct {
    logic [2:0] ci, ce, af;
    logic       rdy, srv;
    logic [2:0] e_pend;
    logic       e_cv;
    logic [1:0] e_cf;
    logic       e_dir, e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] ci, ce, af, input logic rdy, srv,
                     input logic [2:0] pend, input logic cv, input logic [1:0] cf,
                     input logic dir, bsy);
    vec_t v;
    v.ci = ci; v.ce = ce; v.af = af; v.rdy = rdy; v.srv = srv;
    v.e_pend = pend; v.e_cv = cv; v.e_cf = cf; v.e_dir = dir; v.e_busy = bsy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] pend, input logic cv,
                               input logic [1:0] cf, input logic dir, input logic bsy);
    check({tag, ".pending"},   32'(pending),   32'(pend));
    check({tag, ".cmd_valid"}, 32'(cmd_valid), 32'(cv));
    check({tag, ".cmd_floor"}, 32'(cmd_floor), 32'(cf));
    check({tag, ".dir_up"},    32'(dir_up),    32'(dir));
    check({tag, ".busy"},      32'(busy),      32'(bsy));
  endtask

  initial begin
    Reset = 1'b1;
    call_i = '0; call_e = '0; at_floor = '0; cmd_ready = 1'b0; served = 1'b0;

`ifdef CALL_DEBOUNCE_EN
    // 3-cycle press ignored, 4-cycle press sets pending once.
    for (int k = 0; k < 3; k++) add(3'b000, 3'b010, 3'b000, 0, 0, 3'b000, 0, 2'd0, 1, 0);
    add(3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0, 2'd0, 1, 0);
    for (int k = 0; k < 3; k++) add(3'b000, 3'b010, 3'b000, 0, 0, 3'b000, 0, 2'd0, 1, 0);
    add(3'b000, 3'b010, 3'b000, 0, 0, 3'b010, 0, 2'd0, 1, 0);
    add(3'b000, 3'b010, 3'b000, 0, 0, 3'b010, 0, 2'd0, 1, 0);
    add(3'b000, 3'b000, 3'b000, 0, 0, 3'b010, 0, 2'd0, 1, 0);
`else
    // Basic call from floor 0 to floor 2.
    add(3'b000, 3'b100, 3'b001, 0, 0, 3'b100, 0, 2'd0, 1, 0);
    add(3'b000, 3'b000, 3'b001, 0, 0, 3'b100, 1, 2'd2, 1, 0);
    add(3'b000, 3'b000, 3'b001, 1, 0, 3'b100, 0, 2'd2, 1, 1);
    add(3'b000, 3'b000, 3'b010, 0, 0, 3'b100, 0, 2'd2, 1, 1);
    add(3'b000, 3'b000, 3'b100, 0, 1, 3'b000, 0, 2'd2, 1, 0);
    add(3'b000, 3'b000, 3'b100, 0, 0, 3'b000, 0, 2'd2, 1, 0);
    // SCAN: at floor 1 going up with calls at 0 and 2.
    add(3'b001, 3'b100, 3'b010, 0, 0, 3'b101, 0, 2'd2, 1, 0);
    add(3'b000, 3'b000, 3'b010, 0, 0, 3'b101, 1, 2'd2, 1, 0);
    add(3'b000, 3'b000, 3'b010, 1, 0, 3'b101, 0, 2'd2, 1, 1);
    add(3'b000, 3'b000, 3'b100, 0, 1, 3'b001, 0, 2'd2, 1, 0);
    add(3'b000, 3'b000, 3'b100, 0, 0, 3'b001, 1, 2'd0, 0, 0);
    add(3'b000, 3'b000, 3'b100, 1, 0, 3'b001, 0, 2'd0, 0, 1);
    add(3'b000, 3'b000, 3'b001, 0, 1, 3'b000, 0, 2'd0, 0, 0);
    // Reversal at the bottom end, then 10-cycle handshake hold with a cabin press.
    add(3'b000, 3'b100, 3'b001, 0, 0, 3'b100, 0, 2'd0, 0, 0);
    add(3'b000, 3'b000, 3'b001, 0, 0, 3'b100, 1, 2'd2, 1, 0);
    for (int h = 0; h < 10; h++)
      add((h == 2) ? 3'b001 : 3'b000, 3'b000, 3'b001, 0, 0,
          (h >= 2) ? 3'b101 : 3'b100, 1, 2'd2, 1, 0);
    add(3'b000, 3'b000, 3'b001, 1, 0, 3'b101, 0, 2'd2, 1, 1);
    // Clear/press collision, button held one more cycle; reversal at the top end.
    add(3'b000, 3'b100, 3'b100, 0, 1, 3'b001, 0, 2'd2, 1, 0);
    add(3'b000, 3'b100, 3'b100, 0, 0, 3'b101, 1, 2'd0, 0, 0);
    // served outside BUSY is ignored.
    add(3'b000, 3'b000, 3'b100, 0, 1, 3'b101, 1, 2'd0, 0, 0);
    add(3'b000, 3'b000, 3'b100, 1, 0, 3'b101, 0, 2'd0, 0, 1);
    add(3'b000, 3'b000, 3'b001, 0, 1, 3'b100, 0, 2'd0, 0, 0);
    // Between floors and illegal sensor codes hold IDLE.
    add(3'b000, 3'b000, 3'b000, 0, 0, 3'b100, 0, 2'd0, 0, 0);
    add(3'b000, 3'b000, 3'b000, 0, 0, 3'b100, 0, 2'd0, 0, 0);
    add(3'b000, 3'b000, 3'b011, 0, 0, 3'b100, 0, 2'd0, 0, 0);
    add(3'b000, 3'b000, 3'b010, 0, 0, 3'b100, 1, 2'd2, 1, 0);
    add(3'b000, 3'b000, 3'b010, 1, 0, 3'b100, 0, 2'd2, 1, 1);
`endif

    #12;
    check_outputs("reset", 3'b000, 1'b0, 2'd0, 1'b1, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge Clk);
      call_i    = vecs[k].ci;
      call_e    = vecs[k].ce;
      at_floor  = vecs[k].af;
      cmd_ready = vecs[k].rdy;
      served    = vecs[k].srv;
      @(posedge Clk);
      #1;
      check_outputs($sformatf("v%0d", k), vecs[k].e_pend, vecs[k].e_cv,
                    vecs[k].e_cf, vecs[k].e_dir, vecs[k].e_busy);
    end

    @(negedge Clk);
    call_i = '0; call_e = '0; cmd_ready = 1'b0; served = 1'b0;

`ifndef CALL_DEBOUNCE_EN
    // Asynchronous reset while BUSY with a pending call: takes effect without a clock edge.
    #1;
    check("pre_reset.busy", 32'(busy), 32'd1);
    Reset = 1'b1;
    #1;
    check_outputs("async_reset", 3'b000, 1'b0, 2'd0, 1'b1, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check_outputs("post_reset", 3'b000, 1'b0, 2'd0, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
